// File: rtl/fetch_redirect_unit_if.sv
// Instruction-memory fetch port: word-read request/ready handshake between
// the fetch stage (master) and instruction memory (slave).
interface fetch_redirect_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// MIPS instruction-fetch stage with IF/ID pipeline register. Tracks the PC,
// fetches words over a req/ready port, parks a word returned during a decode
// stall, and redirects/squashes on a resolved taken branch.
module fetch_redirect_unit #(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [ADDR_W-1:0]     branch_target,
  fetch_redirect_unit_if.master imem,
  output logic [31:0]           if_instr,
  output logic [ADDR_W-1:0]     if_pc4,
  output logic                  if_valid,
  output logic                  flush
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       buf_q, buf_d;
  logic              req_q, req_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic              flush_q, flush_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] tgt_aligned;
  logic              rdy;

  // Wraps modulo 2^ADDR_W; no overflow indication is needed.
  assign pc_plus4    = pc_q + {{(ADDR_W-3){1'b0}}, 3'b100};
  assign tgt_aligned = branch_target & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  // Ready only counts while a request is actually outstanding.
  assign rdy         = imem.imem_ready & req_q;

  // State, PC, parked word and IF/ID register update; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
      req_q   <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      req_q   <= req_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
    end
  end

  // Next-state: branch redirect beats freeze, which beats normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    flush_d = 1'b0;

    if (branch_taken) begin
      // Any word arriving this cycle is wrong-path and is dropped.
      pc_d    = tgt_aligned;
      valid_d = 1'b0;
      flush_d = 1'b1;
      state_d = FETCH;
      buf_d   = '0;
    end else if (freeze) begin
      // Decode holds; a word returned now is parked so it is not lost.
      if (state_q == FETCH && rdy) begin
        buf_d   = imem.imem_rdata;
        state_d = HOLD;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (rdy) begin
            instr_d = imem.imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          instr_d = buf_q;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end

    // Request is registered so it rises on the first edge after reset.
    req_d = (state_d == FETCH);
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign if_instr       = instr_q;
  assign if_pc4         = pc4_q;
  assign if_valid       = valid_q;
  assign flush          = flush_q;

endmodule
